ysyx_22050710_axi4_rd_arbiter: RTL

- Two-master to one-slave AXI4-full read-channel arbiter. Masters: IFU (single-beat instruction fetch) and LSU (burst-capable loads). Slave: the AXI4-full SRAM wrap.
- One outstanding read at a time. Round-robin on contention.
- The LSU write channels bypass this block and are wired directly to the slave.

---
 rtl/ysyx_22050710_axi4_rd_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22050710_axi4_rd_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 read-channel arbiter.
// One outstanding read, round-robin on contention.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ifu_*/o_ifu_*       IFU read request and beat handshake
//   i_lsu_*/o_lsu_*       LSU read request (bursts) and beat handshake
//   o_rdata, o_rresp      read beat payload shared by both masters
//   o_ar*, i_arready      slave read-address channel
//   i_r*, o_rready        slave read-data channel
module ysyx_22050710_axi4_rd_arbiter #(
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ifu_arvalid,
    output logic               o_ifu_arready,
    input  logic [ADDR_WD-1:0] i_ifu_araddr,
    output logic               o_ifu_rvalid,
    input  logic               i_ifu_rready,
    input  logic               i_lsu_arvalid,
    output logic               o_lsu_arready,
    input  logic [ADDR_WD-1:0] i_lsu_araddr,
    input  logic [7:0]         i_lsu_arlen,
    input  logic [1:0]         i_lsu_arsize,
    output logic               o_lsu_rvalid,
    input  logic               i_lsu_rready,
    output logic               o_lsu_rlast,
    output logic [DATA_WD-1:0] o_rdata,
    output logic [1:0]         o_rresp,
    output logic [3:0]         o_arid,
    output logic [ADDR_WD-1:0] o_araddr,
    output logic [7:0]         o_arlen,
    output logic [1:0]         o_arsize,
    output logic [1:0]         o_arburst,
    output logic               o_arvalid,
    input  logic               i_arready,
    input  logic [3:0]         i_rid,
    input  logic [DATA_WD-1:0] i_rdata,
    input  logic [1:0]         i_rresp,
    input  logic               i_rlast,
    input  logic               i_rvalid,
    output logic               o_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_lsu;
    logic               r_gnt_lsu;
    logic               r_arvalid;
    logic [ADDR_WD-1:0] r_araddr;
    logic [7:0]         r_arlen;
    logic [1:0]         r_arsize;
    logic [3:0]         r_arid;

    logic w_idle;
    logic w_in_r;
    logic w_pick_lsu;
    logic w_pick_ifu;
    logic w_acc;
    logic w_beat;
    logic w_done;
    logic w_unused;

    // RID is not checked; one outstanding read makes it redundant.
    assign w_unused = ^i_rid;

    assign w_idle = (r_state == S_IDLE) & ~i_rst;
    assign w_in_r = (r_state == S_R);

    // LSU wins unless IFU also requests and LSU was served last.
    assign w_pick_lsu = i_lsu_arvalid
                      & (~i_ifu_arvalid | ~r_last_lsu);
    assign w_pick_ifu = i_ifu_arvalid & ~w_pick_lsu;
    assign w_acc      = w_idle & (w_pick_lsu | w_pick_ifu);

    assign o_ifu_arready = w_idle & w_pick_ifu;
    assign o_lsu_arready = w_idle & w_pick_lsu;

    assign o_rready = w_in_r
                    & (r_gnt_lsu ? i_lsu_rready : i_ifu_rready);
    assign o_ifu_rvalid = w_in_r & ~r_gnt_lsu & i_rvalid;
    assign o_lsu_rvalid = w_in_r & r_gnt_lsu & i_rvalid;
    assign o_lsu_rlast  = w_in_r & r_gnt_lsu & i_rlast;
    assign o_rdata = w_in_r ? i_rdata : '0;
    assign o_rresp = w_in_r ? i_rresp : 2'b00;

    // IFU fetches are single-beat: first beat ends it regardless of RLAST.
    assign w_beat = i_rvalid & o_rready;
    assign w_done = w_beat & (i_rlast | ~r_gnt_lsu);

    assign o_arvalid = r_arvalid;
    assign o_araddr  = r_araddr;
    assign o_arlen   = r_arlen;
    assign o_arsize  = r_arsize;
    assign o_arid    = r_arid;
    assign o_arburst = 2'b01;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_last_lsu <= 1'b0;
            r_gnt_lsu  <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= 8'd0;
            r_arsize   <= 2'b00;
            r_arid     <= 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_state    <= S_AR;
                        r_arvalid  <= 1'b1;
                        r_gnt_lsu  <= w_pick_lsu;
                        r_last_lsu <= w_pick_lsu;
                        r_arid     <= {3'b000, w_pick_lsu};
                        if (w_pick_lsu) begin
                            r_araddr <= i_lsu_araddr;
                            r_arlen  <= i_lsu_arlen;
                            r_arsize <= i_lsu_arsize;
                        end else begin
                            r_araddr <= i_ifu_araddr;
                            r_arlen  <= 8'd0;
                            r_arsize <= 2'b10;
                        end
                    end
                end
                S_AR: begin
                    if (i_arready) begin
                        r_state   <= S_R;
                        r_arvalid <= 1'b0;
                    end
                end
                S_R: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
